core_mem_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the core's instruction-fetch port and its load/store data port.
- Sits between the core and a unified memory, and uses a req/gnt/rvalid handshake on each side.
- Arbitrates round-robin, tracks which requester owns the response, and returns read data one cycle after grant.
- Holds the last returned data per port, so the core can stall on a missing gnt.

---
 rtl/core_mem_arbiter.sv | 115 +++++++++++
 tb/tb_core_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the load/store data port. Round-robin
// arbitration, one-cycle read latency, and per-port read-data hold registers.
// DATA_WIDTH is expected to equal 8*TRANSFER_WIDTH; addresses pass through.
module core_mem_arbiter #(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANSFER_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_req_i,
   input  logic [MEM_ADDR_WIDTH-1:0] if_addr_i,
   output logic                      if_gnt_o,
   output logic                      if_rvalid_o,
   output logic [DATA_WIDTH-1:0]     if_rdata_o,
   input  logic                      d_req_i,
   input  logic                      d_we_i,
   input  logic [TRANSFER_WIDTH-1:0] d_be_i,
   input  logic [MEM_ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0]     d_wdata_i,
   output logic                      d_gnt_o,
   output logic                      d_rvalid_o,
   output logic [DATA_WIDTH-1:0]     d_rdata_o,
   output logic                      mem_en_o,
   output logic                      mem_we_o,
   output logic [TRANSFER_WIDTH-1:0] mem_be_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   // Owner of the access issued last cycle, i.e. of this cycle's response.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DR   = 2'd2,
      OWN_DW   = 2'd3
   } owner_e;

   owner_e                  resp_owner_q, resp_owner_d;
   logic                    last_was_d_q, last_was_d_d;
   logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
   logic                    if_gnt, d_gnt;

   // Round-robin grant and memory request mux; nothing is granted in reset.
   always_comb begin
      if_gnt      = 1'b0;
      d_gnt       = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (rst_n) begin
         if (if_req_i && d_req_i) begin
            if (last_was_d_q) if_gnt = 1'b1;
            else              d_gnt  = 1'b1;
         end else if (if_req_i) begin
            if_gnt = 1'b1;
         end else if (d_req_i) begin
            d_gnt = 1'b1;
         end
      end
      if (if_gnt) begin
         mem_be_o   = '1;
         mem_addr_o = if_addr_i;
      end else if (d_gnt) begin
         mem_we_o    = d_we_i;
         mem_be_o    = d_be_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
      end
      mem_en_o = if_gnt | d_gnt;
      if_gnt_o = if_gnt;
      d_gnt_o  = d_gnt;
   end

   // Response routing, read-data capture with same-cycle bypass, next owner.
   always_comb begin
      if_rvalid_o  = rst_n && (resp_owner_q == OWN_IF);
      d_rvalid_o   = rst_n && ((resp_owner_q == OWN_DR) || (resp_owner_q == OWN_DW));
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if (if_rvalid_o) if_rdata_d = mem_rdata_i;
      if (rst_n && (resp_owner_q == OWN_DR)) d_rdata_d = mem_rdata_i;
      if_rdata_o   = if_rdata_d;
      d_rdata_o    = d_rdata_d;
      resp_owner_d = OWN_NONE;
      last_was_d_d = last_was_d_q;
      if (if_gnt) begin
         resp_owner_d = OWN_IF;
         last_was_d_d = 1'b0;
      end else if (d_gnt) begin
         resp_owner_d = d_we_i ? OWN_DW : OWN_DR;
         last_was_d_d = 1'b1;
      end
   end

   // State registers; reset drops any in-flight response and clears held data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_owner_q <= OWN_NONE;
         last_was_d_q <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         resp_owner_q <= resp_owner_d;
         last_was_d_q <= last_was_d_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Testbench for core_mem_arbiter: directed stimulus, a bench SRAM, a
// transaction-level reference model and a per-cycle compare process.
module tb_core_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o, if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          d_req_i, d_we_i;
   logic [TW-1:0] d_be_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic          d_gnt_o, d_rvalid_o;
   logic [DW-1:0] d_rdata_o;
   logic          mem_en_o, mem_we_o;
   logic [TW-1:0] mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   core_mem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
      .d_rdata_o(d_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // Initial memory image shared by the bench SRAM and the model's shadow.
   function automatic logic [DW-1:0] init_word(input int a);
      case (a)
         'h000:   init_word = 32'h1111_0000;
         'h001:   init_word = 32'h2222_0001;
         'h002:   init_word = 32'h3333_0002;
         'h003:   init_word = 32'h4444_0003;
         'h004:   init_word = 32'h0040_0413;
         'h010:   init_word = 32'h00A0_0093;
         'h100:   init_word = 32'hCAFE_0100;
         'h200:   init_word = 32'h0102_0304;
         'h300:   init_word = 32'h1234_5678;
         default: init_word = a * 32'h9E37_79B1;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Bench SRAM: one-cycle read latency, byte-enabled writes.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   initial begin
      logic [DW-1:0] w;
      for (int i = 0; i < (1 << AW); i++) sram[i] = init_word(i);
      mem_rdata_i = '0;
      forever begin
         @(posedge clk);
         if (mem_en_o) begin
            if (mem_we_o) begin
               w = sram[mem_addr_o];
               for (int b = 0; b < TW; b++)
                  if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
               sram[mem_addr_o] <= w;
            end else begin
               mem_rdata_i <= sram[mem_addr_o];
            end
         end
      end
   end

   // Reference model: each grant enqueues a response due next cycle, carrying
   // the data the memory held at grant time.
   typedef struct {
      int            port;   // 1 = fetch, 2 = data
      bit            rd;
      logic [DW-1:0] data;
   } resp_t;

   resp_t         pend_q[$];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   bit            m_last_d = 1'b0;
   logic [DW-1:0] m_if_data = '0;
   logic [DW-1:0] m_d_data = '0;

   function automatic int pick(input bit ireq, input bit dreq, input bit rst, input bit last_d);
      if (!rst) return 0;
      if (ireq && dreq) return last_d ? 1 : 2;
      if (ireq) return 1;
      if (dreq) return 2;
      return 0;
   endfunction

   initial begin
      int            w;
      resp_t         r;
      logic [DW-1:0] word;
      for (int i = 0; i < (1 << AW); i++) shadow[i] = init_word(i);
      forever begin
         @(posedge clk);
         w = pick(if_req_i, d_req_i, rst_n, m_last_d);
         if (!rst_n) begin
            m_last_d = 1'b0;
            pend_q.delete();
            m_if_data = '0;
            m_d_data = '0;
         end else begin
            if (pend_q.size() > 0) begin
               r = pend_q.pop_front();
               if (r.port == 1) m_if_data = r.data;
               else if (r.rd) m_d_data = r.data;
            end
            if (w == 1) begin
               pend_q.push_back('{port: 1, rd: 1'b1, data: shadow[if_addr_i]});
               m_last_d = 1'b0;
            end else if (w == 2) begin
               pend_q.push_back('{port: 2, rd: !d_we_i, data: shadow[d_addr_i]});
               if (d_we_i) begin
                  word = shadow[d_addr_i];
                  for (int b = 0; b < TW; b++)
                     if (d_be_i[b]) word[8*b +: 8] = d_wdata_i[8*b +: 8];
                  shadow[d_addr_i] = word;
               end
               m_last_d = 1'b1;
            end
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   initial begin
      int            w;
      bit            has;
      resp_t         r;
      logic [DW-1:0] e_if, e_d;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            w   = pick(if_req_i, d_req_i, rst_n, m_last_d);
            has = rst_n && (pend_q.size() > 0);
            r   = has ? pend_q[0] : '{port: 0, rd: 1'b0, data: '0};
            e_if = (has && r.port == 1) ? r.data : m_if_data;
            e_d  = (has && r.port == 2 && r.rd) ? r.data : m_d_data;
            chk("if_gnt", 64'(if_gnt_o), 64'(w == 1));
            chk("d_gnt", 64'(d_gnt_o), 64'(w == 2));
            chk("if_rvalid", 64'(if_rvalid_o), 64'(has && r.port == 1));
            chk("d_rvalid", 64'(d_rvalid_o), 64'(has && r.port == 2));
            chk("if_rdata", 64'(if_rdata_o), 64'(e_if));
            chk("d_rdata", 64'(d_rdata_o), 64'(e_d));
            chk("mem_en", 64'(mem_en_o), 64'(w != 0));
            chk("mem_we", 64'(mem_we_o), 64'(w == 2 && d_we_i));
            chk("mem_be", 64'(mem_be_o), 64'((w == 1) ? {TW{1'b1}} : (w == 2) ? d_be_i : '0));
            chk("mem_addr", 64'(mem_addr_o), 64'((w == 1) ? if_addr_i : (w == 2) ? d_addr_i : '0));
            chk("mem_wdata", 64'(mem_wdata_o), 64'((w == 2) ? d_wdata_i : '0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed stimulus with hand-computed expectations.
   initial begin
      logic [DW-1:0] bb [0:3];
      bb[0] = 32'h1111_0000; bb[1] = 32'h2222_0001;
      bb[2] = 32'h3333_0002; bb[3] = 32'h4444_0003;
      rst_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
      tick(); tick();
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_mem_en", 64'(mem_en_o), 64'd0);
      chk("reset_if_rdata", 64'(if_rdata_o), 64'd0);
      chk("reset_d_rdata", 64'(d_rdata_o), 64'd0);
      tick(); rst_n = 1'b1;
      tick();

      // Fetch only
      if_req_i = 1'b1; if_addr_i = 10'h010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fetch_gnt", 64'(if_gnt_o), 64'd1);
         chk("fetch_no_dgnt", 64'(d_gnt_o), 64'd0);
         if (k > 0) chk("fetch_rdata", 64'(if_rdata_o), 64'h00A0_0093);
         tick();
      end
      if_req_i = 1'b0;
      @(negedge clk);
      chk("fetch_last_rvalid", 64'(if_rvalid_o), 64'd1);
      chk("fetch_last_rdata", 64'(if_rdata_o), 64'h00A0_0093);

      // Conflict from reset: data, fetch, data
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      if_req_i = 1'b1; if_addr_i = 10'h004;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 10'h100;
      @(negedge clk);
      chk("conf1_dgnt", 64'(d_gnt_o), 64'd1);
      chk("conf1_ifgnt", 64'(if_gnt_o), 64'd0);
      tick();
      @(negedge clk);
      chk("conf2_ifgnt", 64'(if_gnt_o), 64'd1);
      chk("conf2_d_rdata", 64'(d_rdata_o), 64'hCAFE_0100);
      tick();
      @(negedge clk);
      chk("conf3_dgnt", 64'(d_gnt_o), 64'd1);
      chk("conf3_if_rdata", 64'(if_rdata_o), 64'h0040_0413);
      tick();
      if_req_i = 1'b0; d_req_i = 1'b0;
      @(negedge clk);
      chk("conf4_d_rvalid", 64'(d_rvalid_o), 64'd1);

      // Data write with partial byte enables, then read it back
      tick();
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 10'h200;
      d_wdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_mem_we", 64'(mem_we_o), 64'd1);
      chk("wr_mem_be", 64'(mem_be_o), 64'b0011);
      chk("wr_mem_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
      tick();
      d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_wdata_i = '0;
      @(negedge clk);
      chk("wr_rvalid", 64'(d_rvalid_o), 64'd1);
      chk("wr_rdata_kept", 64'(d_rdata_o), 64'hCAFE_0100);
      tick();
      d_req_i = 1'b1;
      tick();
      d_req_i = 1'b0;
      @(negedge clk);
      chk("wr_readback", 64'(d_rdata_o), 64'h0102_BEEF);

      // Hold across idle cycles
      tick();
      d_req_i = 1'b1; d_addr_i = 10'h300;
      tick();
      d_req_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         @(negedge clk);
         chk("hold_rdata", 64'(d_rdata_o), 64'h1234_5678);
         chk("hold_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'd0);
      end

      // Reset while a read is in flight
      tick();
      d_req_i = 1'b1; d_addr_i = 10'h004;
      @(negedge clk);
      chk("rstmid_gnt", 64'(d_gnt_o), 64'd1);
      #1 rst_n = 1'b0;
      tick();
      rst_n = 1'b1; d_req_i = 1'b0;
      @(negedge clk);
      chk("rstmid_no_rvalid", 64'(d_rvalid_o), 64'd0);
      chk("rstmid_rdata", 64'(d_rdata_o), 64'd0);
      tick();
      if_req_i = 1'b1; if_addr_i = 10'h010; d_req_i = 1'b1; d_addr_i = 10'h100;
      @(negedge clk);
      chk("rstmid_conf_dgnt", 64'(d_gnt_o), 64'd1);
      tick();
      if_req_i = 1'b0; d_req_i = 1'b0;
      tick();

      // Back-to-back data reads
      d_req_i = 1'b1; d_we_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         d_addr_i = AW'(k);
         @(negedge clk);
         chk("b2b_gnt", 64'(d_gnt_o), 64'd1);
         if (k > 0) chk("b2b_rdata", 64'(d_rdata_o), 64'(bb[k-1]));
         tick();
      end
      d_req_i = 1'b0;
      @(negedge clk);
      chk("b2b_last_rvalid", 64'(d_rvalid_o), 64'd1);
      chk("b2b_last_rdata", 64'(d_rdata_o), 64'(bb[3]));
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
